mem_stage: RTL and testbench

- MEM stage of the 5-stage MIPS pipeline, directly downstream of the EX/MEM latch.
- Consumes the latched EX/MEM fields and performs the data-memory load/store handshake against the dcache/arbiter (dhit).
- Raises a stall to freeze IF..EX/MEM while an access is outstanding.
- Owns the MEM/WB pipeline register feeding writeback.

---
 rtl/mem_stage.sv | 199 +++++++++++++++++++
 tb/tb_mem_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Purpose  : MEM stage of the 5-stage MIPS pipeline. Takes the latched
//             EX/MEM fields, performs the load/store handshake with the
//             dcache/arbiter (dhit), stalls the front of the pipe while an
//             access is outstanding, and owns the MEM/WB pipeline register.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    TIMEOUT_CYCLES : cycles spent waiting for dhit before the access is
//                     abandoned (>= 2)
//    CNT_W          : timeout counter width, 2**CNT_W > TIMEOUT_CYCLES
//
//  Ports
//    CLK, RST          clock (rising edge), async active-high reset
//    exmem_*           EX/MEM latch fields (valid, regwr, wsel, memread,
//                      memwrite, alu_out, store_data, halt)
//    wb_flush          squash the instruction entering MEM/WB
//    dhit, dmemload    memory completion strobe and load data
//    dmemREN/WEN       read / write request, held for the whole access
//    dmemaddr/store    address and store data (combinational pass-through)
//    mem_stall         freeze IF, ID, EX and the EX/MEM latch
//    wb_valid/regwr/wsel/data   MEM/WB register outputs
//    halted            sticky: halt has retired
//    mem_err           sticky: misaligned access or timeout
// ============================================================================
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        exmem_valid,
  input  logic        exmem_regwr,
  input  logic [4:0]  exmem_wsel,
  input  logic        exmem_memread,
  input  logic        exmem_memwrite,
  input  logic [31:0] exmem_alu_out,
  input  logic [31:0] exmem_store_data,
  input  logic        exmem_halt,
  input  logic        wb_flush,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic        wb_regwr,
  output logic [4:0]  wb_wsel,
  output logic [31:0] wb_data,
  output logic        halted,
  output logic        mem_err
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_limit = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_halted;
  logic              r_mem_err;
  logic              r_wb_valid;
  logic              r_wb_regwr;
  logic [4:0]        r_wb_wsel;
  logic [31:0]       r_wb_data;

  logic              w_op;
  logic              w_misaligned;
  logic              w_rd_req;
  logic              w_wr_req;
  logic              w_req;
  logic              w_cnt_at_limit;
  logic              w_timeout;
  logic              w_stall;
  logic              w_halt_retire;

  // --------------------------------------------------------------------------
  // Request decode. Once halted no further memory operation is started.
  // A load/store encoding with both memread and memwrite set is a load.
  // Requests are forced low while RST is held so a reset in the middle of
  // an access drops the request in the same cycle rather than at the edge.
  // --------------------------------------------------------------------------
  assign w_op         = exmem_valid & (exmem_memread | exmem_memwrite) & ~r_halted;
  assign w_misaligned = w_op & (exmem_alu_out[1:0] != 2'b00);
  assign w_rd_req     = ~RST & w_op & exmem_memread & ~w_misaligned;
  assign w_wr_req     = ~RST & w_op & exmem_memwrite & ~exmem_memread & ~w_misaligned;
  assign w_req        = w_rd_req | w_wr_req;

  // The counter is 1 in the first BUSY cycle, so reaching the limit with no
  // dhit means TIMEOUT_CYCLES stalled cycles have already elapsed.
  assign w_cnt_at_limit = (r_cnt == c_cnt_limit);
  assign w_timeout      = (r_state == ST_BUSY) & ~dhit & w_cnt_at_limit;

  // --------------------------------------------------------------------------
  // Stall: raised combinationally in the first cycle of a miss so the
  // upstream latches freeze immediately; released in the completion cycle
  // (dhit or timeout) so the instruction moves into MEM/WB on that edge.
  // --------------------------------------------------------------------------
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      ST_IDLE: w_stall = w_req & ~dhit;
      ST_BUSY: w_stall = ~dhit & ~w_cnt_at_limit;
      default: w_stall = 1'b0;
    endcase
  end

  // A halt retires only when it actually leaves MEM (not stalled) unflushed.
  assign w_halt_retire = ~w_stall & exmem_valid & exmem_halt & ~wb_flush & ~r_halted;

  // --------------------------------------------------------------------------
  // Access FSM and timeout counter.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req && !dhit) begin
            r_state <= ST_BUSY;
            r_cnt   <= c_cnt_one;
          end
        end
        ST_BUSY: begin
          if (dhit || w_cnt_at_limit) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt   <= r_cnt + c_cnt_one;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // MEM/WB pipeline register. During a stall a bubble is inserted and the
  // payload fields hold. wb_flush is only honoured when not stalled; an
  // access already issued is always carried to completion.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wb_valid <= 1'b0;
      r_wb_regwr <= 1'b0;
      r_wb_wsel  <= '0;
      r_wb_data  <= '0;
    end else if (w_stall) begin
      r_wb_valid <= 1'b0;
    end else begin
      r_wb_valid <= exmem_valid & ~wb_flush & ~r_halted;
      r_wb_regwr <= exmem_regwr & ~wb_flush & ~w_misaligned & ~w_timeout & ~r_halted;
      r_wb_wsel  <= exmem_wsel;
      r_wb_data  <= exmem_memread ? dmemload : exmem_alu_out;
    end
  end

  // Sticky status flags; only reset clears them.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_halted  <= 1'b0;
      r_mem_err <= 1'b0;
    end else begin
      if (w_halt_retire) begin
        r_halted <= 1'b1;
      end
      if (w_misaligned || w_timeout) begin
        r_mem_err <= 1'b1;
      end
    end
  end

  assign dmemREN   = w_rd_req;
  assign dmemWEN   = w_wr_req;
  assign dmemaddr  = exmem_alu_out;
  assign dmemstore = exmem_store_data;
  assign mem_stall = w_stall;
  assign wb_valid  = r_wb_valid;
  assign wb_regwr  = r_wb_regwr;
  assign wb_wsel   = r_wb_wsel;
  assign wb_data   = r_wb_data;
  assign halted    = r_halted;
  assign mem_err   = r_mem_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage
//  Purpose  : Directed self-checking bench for mem_stage (TIMEOUT_CYCLES=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        exmem_valid, exmem_regwr, exmem_memread, exmem_memwrite, exmem_halt;
  logic [4:0]  exmem_wsel;
  logic [31:0] exmem_alu_out, exmem_store_data;
  logic        wb_flush, dhit;
  logic [31:0] dmemload;
  logic        dmemREN, dmemWEN, mem_stall, wb_valid, wb_regwr, halted, mem_err;
  logic [31:0] dmemaddr, dmemstore, wb_data;
  logic [4:0]  wb_wsel;

  int tests  = 0;
  int failed = 0;

  mem_stage #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
    .CLK(CLK), .RST(RST),
    .exmem_valid(exmem_valid), .exmem_regwr(exmem_regwr), .exmem_wsel(exmem_wsel),
    .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite),
    .exmem_alu_out(exmem_alu_out), .exmem_store_data(exmem_store_data),
    .exmem_halt(exmem_halt), .wb_flush(wb_flush), .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall), .wb_valid(wb_valid), .wb_regwr(wb_regwr), .wb_wsel(wb_wsel),
    .wb_data(wb_data), .halted(halted), .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic rw, input logic [4:0] ws,
                        input logic rd, input logic wr, input logic [31:0] alu,
                        input logic [31:0] sd, input logic h);
    exmem_valid = v; exmem_regwr = rw; exmem_wsel = ws; exmem_memread = rd;
    exmem_memwrite = wr; exmem_alu_out = alu; exmem_store_data = sd; exmem_halt = h;
  endtask

  initial begin
    RST = 1'b1; wb_flush = 1'b0; dhit = 1'b0; dmemload = '0;
    // A lw is presented during reset: the request must stay low.
    set_ex(1, 1, 5'd5, 1, 0, 32'h40, 32'h0, 0);
    #12;
    check("rst_ren",      {31'b0, dmemREN},   32'd0);
    check("rst_stall",    {31'b0, mem_stall}, 32'd0);
    check("rst_wb_valid", {31'b0, wb_valid},  32'd0);
    check("rst_wb_data",  wb_data,            32'd0);
    check("rst_halted",   {31'b0, halted},    32'd0);
    check("rst_mem_err",  {31'b0, mem_err},   32'd0);
    RST = 1'b0;

    // ---- lw 0x40, dhit three cycles after the request ----
    #1;
    check("lw_ren_c0",   {31'b0, dmemREN},   32'd1);
    check("lw_stall_c0", {31'b0, mem_stall}, 32'd1);
    check("lw_addr",     dmemaddr,           32'h40);
    tick();
    check("lw_bubble_c1", {31'b0, wb_valid},  32'd0);
    check("lw_stall_c1",  {31'b0, mem_stall}, 32'd1);
    check("lw_ren_c1",    {31'b0, dmemREN},   32'd1);
    tick();
    check("lw_bubble_c2", {31'b0, wb_valid},  32'd0);
    check("lw_stall_c2",  {31'b0, mem_stall}, 32'd1);
    tick();
    check("lw_bubble_c3", {31'b0, wb_valid},  32'd0);
    dhit = 1'b1; dmemload = 32'hDEADBEEF;
    #1;
    check("lw_ren_c3",   {31'b0, dmemREN},   32'd1);
    check("lw_stall_c3", {31'b0, mem_stall}, 32'd0);
    tick();
    check("lw_wb_valid", {31'b0, wb_valid}, 32'd1);
    check("lw_wb_regwr", {31'b0, wb_regwr}, 32'd1);
    check("lw_wb_data",  wb_data,           32'hDEADBEEF);
    check("lw_wb_wsel",  {27'b0, wb_wsel},  32'd5);

    // ---- sw 0x100 data 0x1234, dhit same cycle ----
    set_ex(1, 0, 5'd0, 0, 1, 32'h100, 32'h1234, 0);
    dhit = 1'b1;
    #1;
    check("sw_wen",   {31'b0, dmemWEN},   32'd1);
    check("sw_ren",   {31'b0, dmemREN},   32'd0);
    check("sw_stall", {31'b0, mem_stall}, 32'd0);
    check("sw_store", dmemstore,          32'h1234);
    tick();
    check("sw_wb_valid", {31'b0, wb_valid}, 32'd1);
    check("sw_wb_regwr", {31'b0, wb_regwr}, 32'd0);
    set_ex(0, 0, 5'd0, 0, 0, 32'h0, 32'h0, 0);
    dhit = 1'b0;
    #1;
    check("sw_wen_drop", {31'b0, dmemWEN}, 32'd0);

    // ---- add (alu=7, wsel=3) then lw with same-cycle dhit ----
    set_ex(1, 1, 5'd3, 0, 0, 32'd7, 32'h0, 0);
    #1;
    check("add_stall", {31'b0, mem_stall}, 32'd0);
    tick();
    check("add_wb_valid", {31'b0, wb_valid}, 32'd1);
    check("add_wb_data",  wb_data,           32'd7);
    check("add_wb_wsel",  {27'b0, wb_wsel},  32'd3);
    set_ex(1, 1, 5'd4, 1, 0, 32'h80, 32'h0, 0);
    dhit = 1'b1; dmemload = 32'hCAFEF00D;
    #1;
    check("b2b_stall", {31'b0, mem_stall}, 32'd0);
    tick();
    check("b2b_wb_valid", {31'b0, wb_valid}, 32'd1);
    check("b2b_wb_data",  wb_data,           32'hCAFEF00D);
    check("b2b_wb_wsel",  {27'b0, wb_wsel},  32'd4);
    check("b2b_wb_regwr", {31'b0, wb_regwr}, 32'd1);
    dhit = 1'b0;

    // ---- flushed add ----
    set_ex(1, 1, 5'd7, 0, 0, 32'd9, 32'h0, 0);
    wb_flush = 1'b1;
    tick();
    check("flush_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("flush_wb_regwr", {31'b0, wb_regwr}, 32'd0);
    wb_flush = 1'b0;

    // ---- misaligned lw 0x42 ----
    set_ex(1, 1, 5'd6, 1, 0, 32'h42, 32'h0, 0);
    #1;
    check("mis_ren",   {31'b0, dmemREN},   32'd0);
    check("mis_stall", {31'b0, mem_stall}, 32'd0);
    check("mis_err_before", {31'b0, mem_err}, 32'd0);
    tick();
    check("mis_err",      {31'b0, mem_err},  32'd1);
    check("mis_wb_valid", {31'b0, wb_valid}, 32'd1);
    check("mis_wb_regwr", {31'b0, wb_regwr}, 32'd0);

    // Reset to clear the sticky error before the timeout case.
    set_ex(0, 0, 5'd0, 0, 0, 32'h0, 32'h0, 0);
    RST = 1'b1;
    #2;
    check("rst2_mem_err", {31'b0, mem_err}, 32'd0);
    RST = 1'b0;
    tick();

    // ---- timeout: lw, dhit never (TIMEOUT_CYCLES=4) ----
    set_ex(1, 1, 5'd8, 1, 0, 32'h10, 32'h0, 0);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("to_stall_c%0d", i), {31'b0, mem_stall}, 32'd1);
      tick();
    end
    check("to_stall_c4",   {31'b0, mem_stall}, 32'd0);
    check("to_err_before", {31'b0, mem_err},   32'd0);
    tick();
    check("to_err",      {31'b0, mem_err},  32'd1);
    check("to_wb_valid", {31'b0, wb_valid}, 32'd1);
    check("to_wb_regwr", {31'b0, wb_regwr}, 32'd0);
    // FSM back in IDLE: a hit-same-cycle lw completes with no stall.
    set_ex(1, 1, 5'd9, 1, 0, 32'h20, 32'h0, 0);
    dhit = 1'b1; dmemload = 32'h0000_5A5A;
    #1;
    check("to_idle_stall", {31'b0, mem_stall}, 32'd0);
    tick();
    check("to_idle_wb_data",  wb_data,           32'h0000_5A5A);
    check("to_idle_wb_regwr", {31'b0, wb_regwr}, 32'd1);
    dhit = 1'b0;

    // ---- reset during BUSY ----
    set_ex(1, 1, 5'd10, 1, 0, 32'h44, 32'h0, 0);
    tick();
    tick();
    check("busy_ren", {31'b0, dmemREN}, 32'd1);
    RST = 1'b1;
    #1;
    check("rstbusy_ren",      {31'b0, dmemREN},   32'd0);
    check("rstbusy_stall",    {31'b0, mem_stall}, 32'd0);
    check("rstbusy_wb_valid", {31'b0, wb_valid},  32'd0);
    check("rstbusy_wb_data",  wb_data,            32'd0);
    check("rstbusy_mem_err",  {31'b0, mem_err},   32'd0);
    set_ex(0, 0, 5'd0, 0, 0, 32'h0, 32'h0, 0);
    tick();
    RST = 1'b0;

    // ---- halt retires, then a lw issues nothing ----
    set_ex(1, 0, 5'd0, 0, 0, 32'h0, 32'h0, 1);
    tick();
    check("halt_halted",   {31'b0, halted},   32'd1);
    check("halt_wb_valid", {31'b0, wb_valid}, 32'd1);
    set_ex(1, 1, 5'd11, 1, 0, 32'h40, 32'h0, 0);
    #1;
    check("halted_ren",   {31'b0, dmemREN},   32'd0);
    check("halted_stall", {31'b0, mem_stall}, 32'd0);
    tick();
    check("halted_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("halted_sticky",   {31'b0, halted},   32'd1);
    check("halted_no_err",   {31'b0, mem_err},  32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Safety net so the bench always terminates.
  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
